// File: rtl/eth_frame_parser_pkg.sv
// Shared types and constants for the Ethernet frame parser front end.
// Build option: define ETH_PARSE_VLAN_EN to decode a single 802.1Q tag.
package eth_frame_parser_pkg;

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;
   localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   // Index of the final header byte, untagged and tagged.
   localparam logic [4:0]  HDR_LAST_BASE = 5'd13;
   localparam logic [4:0]  HDR_LAST_VLAN = 5'd17;

   // Parser states, kept as plain constants for drop-in use by older blocks.
   localparam logic [1:0]  S_HUNT = 2'd0;
   localparam logic [1:0]  S_HDR  = 2'd1;
   localparam logic [1:0]  S_PAY  = 2'd2;

   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [15:0] ethertype;
      logic        vlan_present;
      logic [15:0] vlan_tci;
   } eth_hdr_ext_t;

   // Consecutive-preamble counter; it only has to reach 7.
   function automatic logic [2:0] pre_cnt_inc(input logic [2:0] cnt);
      return (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
   endfunction

endpackage

// File: rtl/eth_frame_parser_if.sv
// AXI-Stream ingress plus header side channel of the frame parser.
// master = environment driving frames / taking records, slave = the parser.
interface eth_frame_parser_if #(
   parameter int DATA_W = 64
) ();
   import eth_frame_parser_pkg::*;

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] s_axis_tdata;
   logic [NB-1:0]     s_axis_tkeep;
   logic              s_axis_tvalid;
   logic              s_axis_tlast;
   logic              s_axis_tready;

   logic              m_hdr_valid;
   logic              m_hdr_ready;
   eth_hdr_ext_t      m_hdr;

   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
      input  s_axis_tready,
      input  m_hdr_valid, m_hdr,
      output m_hdr_ready
   );

   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
      output s_axis_tready,
      output m_hdr_valid, m_hdr,
      input  m_hdr_ready
   );
endinterface

// File: rtl/eth_frame_parser_stats.sv
// Saturating frame / runt statistics counters for the frame parser.
module eth_parse_stats #(
   parameter int CNT_W = 16
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             inc_frame,
   input  logic             inc_runt,
   output logic [CNT_W-1:0] stat_frames,
   output logic [CNT_W-1:0] stat_runts
);

   // Count each strobe, holding at all-ones instead of wrapping.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stat_frames <= '0;
         stat_runts  <= '0;
      end else begin
         if (inc_frame && (stat_frames != '1)) stat_frames <= stat_frames + CNT_W'(1);
         if (inc_runt  && (stat_runts  != '1)) stat_runts  <= stat_runts  + CNT_W'(1);
      end
   end

endmodule

// File: rtl/eth_frame_parser.sv
// Multi-lane Ethernet frame parser: preamble/SFD hunt, header extraction,
// one header record per frame plus IPv4/IPv6 start strobes.
// Build option: ETH_PARSE_VLAN_EN enables 802.1Q tag decoding (18-byte header).
module eth_frame_parser
   import eth_frame_parser_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int PRE_MIN = 7,
   parameter int CNT_W   = 16
) (
   input  logic              aclk,
   input  logic              aresetn,
   eth_frame_parser_if.slave bus,
   output logic              start_ipv4,
   output logic              start_ipv6,
   output logic              frame_err,
   output logic [CNT_W-1:0]  stat_frames,
   output logic [CNT_W-1:0]  stat_runts
);

   localparam int         NB        = DATA_W / 8;
   localparam logic [2:0] PRE_MIN_C = 3'(PRE_MIN);

   logic [1:0]   state_q,    state_n;
   logic [2:0]   pre_cnt_q,  pre_cnt_n;
   logic [4:0]   byte_idx_q, byte_idx_n;
   eth_hdr_ext_t work_q,     work_n;
   eth_hdr_ext_t hdr_q;
   logic         hdr_valid_q;
   logic         hdr_done;
   logic         runt;
   logic         hdr_last;
   logic [7:0]   lane_byte;
   logic         tready;
   logic         beat_acc;

   // Header bytes arrive MSB first, so each field is a shift register cleared at the SFD.
   function automatic eth_hdr_ext_t put_byte(input eth_hdr_ext_t h, input logic [4:0] idx,
                                             input logic [7:0] b);
      eth_hdr_ext_t r;
      r = h;
      if (idx < 5'd6)       r.dst_mac   = {h.dst_mac[39:0], b};
      else if (idx < 5'd12) r.src_mac   = {h.src_mac[39:0], b};
      else if (idx < 5'd14) r.ethertype = {h.ethertype[7:0], b};
`ifdef ETH_PARSE_VLAN_EN
      else if (idx < 5'd16) r.vlan_tci  = {h.vlan_tci[7:0], b};
      else                  r.ethertype = {h.ethertype[7:0], b};
      if ((idx == HDR_LAST_BASE) && (r.ethertype == ETH_TYPE_VLAN)) r.vlan_present = 1'b1;
`endif
      return r;
   endfunction

   // A pending record stalls all input until it is consumed.
   assign tready            = !(hdr_valid_q && !bus.m_hdr_ready);
   assign beat_acc          = bus.s_axis_tvalid && tready;
   assign bus.s_axis_tready = tready;
   assign bus.m_hdr_valid   = hdr_valid_q;
   assign bus.m_hdr         = hdr_q;

   // Walk the lanes of the current beat in wire order, starting from the registered state.
   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_n    = state_q;
      pre_cnt_n  = pre_cnt_q;
      byte_idx_n = byte_idx_q;
      work_n     = work_q;
      hdr_done   = 1'b0;
      runt       = 1'b0;
      hdr_last   = 1'b0;
      lane_byte  = '0;
      for (int i = 0; i < NB; i++) begin
         lane_byte = bus.s_axis_tdata[8*i +: 8];
         if (bus.s_axis_tkeep[i]) begin
            case (state_n)
               S_HUNT: begin
                  if (lane_byte == PREAMBLE_BYTE) begin
                     pre_cnt_n = pre_cnt_inc(pre_cnt_n);
                  end else if ((lane_byte == SFD_BYTE) && (pre_cnt_n >= PRE_MIN_C)) begin
                     state_n    = S_HDR;
                     byte_idx_n = '0;
                     pre_cnt_n  = '0;
                     work_n     = '0;
                  end else begin
                     pre_cnt_n = '0;
                  end
               end
               S_HDR: begin
                  work_n = put_byte(work_n, byte_idx_n, lane_byte);
`ifdef ETH_PARSE_VLAN_EN
                  hdr_last = ((byte_idx_n == HDR_LAST_BASE) && !work_n.vlan_present) ||
                             (byte_idx_n == HDR_LAST_VLAN);
`else
                  hdr_last = (byte_idx_n == HDR_LAST_BASE);
`endif
                  if (hdr_last) begin
                     state_n  = S_PAY;
                     hdr_done = 1'b1;
                  end else begin
                     byte_idx_n = byte_idx_n + 5'd1;
                  end
               end
               default: ;
            endcase
         end
      end
      // Lanes past the tlast lane carry no keep, so ending the frame here
      // is the same as ending it at the tlast lane itself.
      if (bus.s_axis_tlast) begin
         runt      = (state_n == S_HDR);
         state_n   = S_HUNT;
         pre_cnt_n = '0;
      end
   end

   // Commit the lane walk once per accepted beat; manage the record handshake and strobes.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= S_HUNT;
         pre_cnt_q   <= '0;
         byte_idx_q  <= '0;
         work_q      <= '0;
         hdr_q       <= '0;
         hdr_valid_q <= 1'b0;
         start_ipv4  <= 1'b0;
         start_ipv6  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         if (beat_acc) begin
            state_q    <= state_n;
            pre_cnt_q  <= pre_cnt_n;
            byte_idx_q <= byte_idx_n;
            work_q     <= work_n;
         end
         start_ipv4 <= beat_acc && hdr_done && (work_n.ethertype == ETH_TYPE_IPV4);
         start_ipv6 <= beat_acc && hdr_done && (work_n.ethertype == ETH_TYPE_IPV6);
         frame_err  <= beat_acc && runt;
         if (beat_acc && hdr_done) begin
            hdr_valid_q <= 1'b1;
            hdr_q       <= work_n;
         end else if (bus.m_hdr_ready) begin
            hdr_valid_q <= 1'b0;
         end
      end
   end

   eth_parse_stats #(.CNT_W(CNT_W)) u_stats (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .inc_frame   (beat_acc && hdr_done),
      .inc_runt    (beat_acc && runt),
      .stat_frames (stat_frames),
      .stat_runts  (stat_runts)
   );

endmodule
